// File: rtl/uart_rx_core_if.sv
// ============================================================================
// Module      : uart_rx_core_if
// Description : Serial-in / byte-out bundle for the 8N1 UART receiver.
//               master = line driver and byte consumer, slave = receiver core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_rx_core_if;
  logic       rx;
  logic [7:0] rx_byte;
  logic       received;
  logic       recv_error;
  logic       break_det;
  logic       is_receiving;

  modport master (
    output rx,
    input  rx_byte,
    input  received,
    input  recv_error,
    input  break_det,
    input  is_receiving
  );

  modport slave (
    input  rx,
    output rx_byte,
    output received,
    output recv_error,
    output break_det,
    output is_receiving
  );
endinterface

`default_nettype wire

// File: rtl/uart_rx_core.sv
// ============================================================================
// Module      : uart_rx_core
// Description : 8N1 asynchronous serial receiver with 16x oversampling,
//               3-sample majority vote per bit, stop-bit check and break
//               detection. Good bytes are presented with a one-cycle strobe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_core #(
  parameter int CLK_DIV = 27
) (
  input  wire logic       clk,
  input  wire logic       rst,
  uart_rx_core_if.slave   bus
);

  localparam logic [15:0] c_DIV_LAST = 16'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_IDLE = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_rx_meta;
  logic        r_rx_s;
  logic        r_rx_d;
  logic [15:0] r_div;
  logic [3:0]  r_sample_cnt;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shift;
  logic        r_s7;
  logic        r_s8;

  logic [7:0]  r_rx_byte;
  logic        r_received;
  logic        r_recv_error;
  logic        r_break_det;
  logic        r_is_receiving;

  logic        w_tick;
  logic        w_fall;
  logic        w_vote;
  logic        w_mid;
  logic        w_end;
  logic        w_restart;
  logic        w_shift_en;
  logic        w_bit_clr;
  logic        w_bit_adv;
  logic        w_rcv;
  logic        w_err;

  assign w_tick = (r_div == c_DIV_LAST);
  assign w_fall = r_rx_d & ~r_rx_s;
  // Third sample is the live synchronized line on the tick where sample_cnt is 9
  assign w_vote = (r_s7 & r_s8) | (r_s7 & r_rx_s) | (r_s8 & r_rx_s);
  assign w_mid  = w_tick && (r_sample_cnt == 4'd9);
  assign w_end  = w_tick && (r_sample_cnt == 4'd15);

  // Two-flop synchronizer plus one delay stage for falling-edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_d    <= 1'b1;
    end else begin
      r_rx_meta <= bus.rx;
      r_rx_s    <= r_rx_meta;
      r_rx_d    <= r_rx_s;
    end
  end

  // Oversample tick divider, re-phased to the detected start edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div <= '0;
    end else if (w_restart || w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 16'd1;
    end
  end

  // Position within the current bit (0..15), wraps naturally
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sample_cnt <= '0;
    end else if (w_restart) begin
      r_sample_cnt <= '0;
    end else if (w_tick) begin
      r_sample_cnt <= r_sample_cnt + 4'd1;
    end
  end

  // Capture the first two of the three mid-bit samples
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s7 <= 1'b1;
      r_s8 <= 1'b1;
    end else if (w_tick) begin
      if (r_sample_cnt == 4'd7) r_s7 <= r_rx_s;
      if (r_sample_cnt == 4'd8) r_s8 <= r_rx_s;
    end
  end

  // Data bit index and LSB-first shift register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      if (w_bit_clr) begin
        r_bit_idx <= '0;
      end else if (w_bit_adv) begin
        r_bit_idx <= r_bit_idx + 3'd1;
      end
      if (w_shift_en) begin
        r_shift <= {w_vote, r_shift[7:1]};
      end
    end
  end

  // Frame state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and per-cycle control decode
  always_comb begin
    w_state_nxt = r_state;
    w_restart   = 1'b0;
    w_shift_en  = 1'b0;
    w_bit_clr   = 1'b0;
    w_bit_adv   = 1'b0;
    w_rcv       = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fall) begin
          w_restart   = 1'b1;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_mid && w_vote) begin
          // Line was high again at mid start bit: treat as a glitch
          w_state_nxt = S_IDLE;
        end else if (w_end) begin
          w_bit_clr   = 1'b1;
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (w_mid) begin
          w_shift_en = 1'b1;
        end
        if (w_end) begin
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = S_STOP;
          end else begin
            w_bit_adv = 1'b1;
          end
        end
      end
      S_STOP: begin
        if (w_mid) begin
          if (w_vote) begin
            // Leave at mid-stop so a back-to-back start edge is not missed
            w_rcv       = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_err       = 1'b1;
            w_state_nxt = S_WAIT_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        // Hold here while the line is low so a long break is reported once
        if (r_rx_s) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Registered outputs: strobes, held byte and busy flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_byte      <= '0;
      r_received     <= 1'b0;
      r_recv_error   <= 1'b0;
      r_break_det    <= 1'b0;
      r_is_receiving <= 1'b0;
    end else begin
      r_received     <= w_rcv;
      r_recv_error   <= w_err;
      r_break_det    <= w_err && (r_shift == 8'h00);
      r_is_receiving <= (w_state_nxt != S_IDLE);
      if (w_rcv) begin
        r_rx_byte <= r_shift;
      end
    end
  end

  assign bus.rx_byte      = r_rx_byte;
  assign bus.received     = r_received;
  assign bus.recv_error   = r_recv_error;
  assign bus.break_det    = r_break_det;
  assign bus.is_receiving = r_is_receiving;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_core.sv
// ============================================================================
// Module      : tb_uart_rx_core
// Description : Directed self-checking bench for uart_rx_core (CLK_DIV=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_rx_core;

  localparam int  c_CLK_DIV = 4;
  localparam real c_CLK_NS  = 10.0;
  localparam real c_BIT_NS  = 16.0 * c_CLK_DIV * c_CLK_NS;

  logic clk;
  logic rst;

  uart_rx_core_if bus_if();

  uart_rx_core #(.CLK_DIV(c_CLK_DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;

  // Event counters and received-byte log, sampled on the falling edge
  int         n_rcv;
  int         n_err;
  int         n_brk;
  int         n_isr_rise;
  int         n_isr_fall;
  logic       prev_isr;
  logic [7:0] rx_log [$];

  always @(negedge clk) begin
    if (rst) begin
      if (bus_if.received) begin
        n_rcv = n_rcv + 1;
        rx_log.push_back(bus_if.rx_byte);
      end
      if (bus_if.recv_error) n_err = n_err + 1;
      if (bus_if.break_det)  n_brk = n_brk + 1;
      if (!prev_isr &&  bus_if.is_receiving) n_isr_rise = n_isr_rise + 1;
      if ( prev_isr && !bus_if.is_receiving) n_isr_fall = n_isr_fall + 1;
    end
    prev_isr = bus_if.is_receiving;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input real bit_ns);
    bus_if.rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      bus_if.rx = b[i];
      #(bit_ns);
    end
    bus_if.rx = stop_bit;
    #(bit_ns);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [7:0] b2b_bytes  [3]  = '{8'h00, 8'hFF, 8'h55};
  logic [7:0] skew_bytes [16] = '{8'h01, 8'h80, 8'hA5, 8'h5A, 8'hFF, 8'h00, 8'h3C, 8'hC3,
                                  8'h7E, 8'h81, 8'h55, 8'hAA, 8'h12, 8'hED, 8'h0F, 8'hF0};

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  base_rcv, base_err, base_brk, base_rise, base_fall, base_q;
    int  cyc;
    real bit_ns;

    n_checks = 0; n_fail = 0;
    n_rcv = 0; n_err = 0; n_brk = 0; n_isr_rise = 0; n_isr_fall = 0;
    prev_isr = 1'b0;
    rst = 1'b0;
    bus_if.rx = 1'b1;

    // Reset state
    idle_cycles(5);
    check_eq("rst_rx_byte",      bus_if.rx_byte,      8'h00);
    check_eq("rst_received",     bus_if.received,     1'b0);
    check_eq("rst_recv_error",   bus_if.recv_error,   1'b0);
    check_eq("rst_break_det",    bus_if.break_det,    1'b0);
    check_eq("rst_is_receiving", bus_if.is_receiving, 1'b0);
    rst = 1'b1;
    idle_cycles(10);

    // Single byte 0xA5 with latency measurement from the pin edge
    base_rcv = n_rcv; base_err = n_err;
    cyc = 0;
    fork
      send_frame(8'hA5, 1'b1, c_BIT_NS);
      begin
        while (cyc < 800) begin
          @(posedge clk);
          cyc = cyc + 1;
          #1;
          if (bus_if.received) break;
        end
      end
    join
    check_eq("single_latency_620pm1", (cyc >= 619 && cyc <= 621), 1'b1);
    idle_cycles(20);
    check_eq("single_count",   n_rcv - base_rcv, 1);
    check_eq("single_byte",    bus_if.rx_byte,   8'hA5);
    check_eq("single_no_err",  n_err - base_err, 0);

    // Back-to-back frames with no idle gap
    base_rcv = n_rcv; base_err = n_err; base_fall = n_isr_fall; base_q = rx_log.size();
    for (int i = 0; i < 3; i++) send_frame(b2b_bytes[i], 1'b1, c_BIT_NS);
    idle_cycles(200);
    check_eq("b2b_count",    n_rcv - base_rcv, 3);
    check_eq("b2b_no_err",   n_err - base_err, 0);
    check_eq("b2b_isr_fall", n_isr_fall - base_fall, 3);
    for (int i = 0; i < 3; i++) begin
      if (rx_log.size() > base_q + i) check_eq("b2b_byte", rx_log[base_q + i], b2b_bytes[i]);
      else                            check_eq("b2b_byte_missing", 0, 1);
    end

    // Glitch shorter than half a bit
    base_rcv = n_rcv; base_err = n_err; base_rise = n_isr_rise; base_fall = n_isr_fall;
    bus_if.rx = 1'b0;
    idle_cycles(3 * c_CLK_DIV);
    bus_if.rx = 1'b1;
    idle_cycles(200);
    check_eq("glitch_no_rcv",    n_rcv - base_rcv, 0);
    check_eq("glitch_no_err",    n_err - base_err, 0);
    check_eq("glitch_isr_rise",  n_isr_rise - base_rise, 1);
    check_eq("glitch_isr_fall",  n_isr_fall - base_fall, 1);
    check_eq("glitch_isr_low",   bus_if.is_receiving, 1'b0);

    // Framing error: 0x3C with stop bit 0
    base_rcv = n_rcv; base_err = n_err; base_brk = n_brk;
    send_frame(8'h3C, 1'b0, c_BIT_NS);
    bus_if.rx = 1'b1;
    idle_cycles(200);
    check_eq("ferr_err_pulse", n_err - base_err, 1);
    check_eq("ferr_no_break",  n_brk - base_brk, 0);
    check_eq("ferr_no_rcv",    n_rcv - base_rcv, 0);
    check_eq("ferr_byte_held", bus_if.rx_byte,   8'h55);
    check_eq("ferr_isr_low",   bus_if.is_receiving, 1'b0);

    // Line break for 20 bit periods, then a good 0x81
    base_rcv = n_rcv; base_err = n_err; base_brk = n_brk;
    bus_if.rx = 1'b0;
    #(20.0 * c_BIT_NS);
    check_eq("break_isr_held", bus_if.is_receiving, 1'b1);
    bus_if.rx = 1'b1;
    idle_cycles(200);
    check_eq("break_err_once", n_err - base_err, 1);
    check_eq("break_det_once", n_brk - base_brk, 1);
    send_frame(8'h81, 1'b1, c_BIT_NS);
    idle_cycles(100);
    check_eq("break_next_count", n_rcv - base_rcv, 1);
    check_eq("break_next_byte",  bus_if.rx_byte,   8'h81);

    // Reset asserted during data bit 4
    base_rcv = n_rcv; base_err = n_err;
    bus_if.rx = 1'b0;
    #(c_BIT_NS);
    for (int i = 0; i < 4; i++) begin
      bus_if.rx = (8'h5A >> i) & 8'h01;
      #(c_BIT_NS);
    end
    bus_if.rx = 1'b1;
    #(c_BIT_NS / 2.0);
    check_eq("mid_isr_before", bus_if.is_receiving, 1'b1);
    rst = 1'b0;
    #1;
    check_eq("mid_rst_byte", bus_if.rx_byte,      8'h00);
    check_eq("mid_rst_isr",  bus_if.is_receiving, 1'b0);
    check_eq("mid_rst_rcv",  bus_if.received,     1'b0);
    idle_cycles(5);
    rst = 1'b1;
    idle_cycles(2000);
    check_eq("mid_no_rcv", n_rcv - base_rcv, 0);
    check_eq("mid_no_err", n_err - base_err, 0);
    send_frame(8'h7E, 1'b1, c_BIT_NS);
    idle_cycles(100);
    check_eq("mid_next_count", n_rcv - base_rcv, 1);
    check_eq("mid_next_byte",  bus_if.rx_byte,   8'h7E);

    // Sender bit rate skewed +3% and -3%
    for (int s = 0; s < 2; s++) begin
      bit_ns = (s == 0) ? c_BIT_NS * 1.03 : c_BIT_NS * 0.97;
      base_rcv = n_rcv; base_err = n_err; base_q = rx_log.size();
      for (int i = 0; i < 16; i++) send_frame(skew_bytes[i], 1'b1, bit_ns);
      idle_cycles(200);
      check_eq("skew_count",  n_rcv - base_rcv, 16);
      check_eq("skew_no_err", n_err - base_err, 0);
      for (int i = 0; i < 16; i++) begin
        if (rx_log.size() > base_q + i) check_eq("skew_byte", rx_log[base_q + i], skew_bytes[i]);
        else                            check_eq("skew_byte_missing", 0, 1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_rx_core.md
# uart_rx_core

Standalone serial receiver for 8N1 asynchronous frames: the receive-side companion to the codebase's UART transmit path. It samples the `rx` line at 16x the bit rate, validates the start bit, majority-votes each data bit, checks the stop bit, and presents each good byte with a one-cycle `received` strobe. This strobe pushes directly into the 8-bit RX FIFO. Framing errors and line breaks are flagged as one-cycle pulses for the interrupt logic.

## Interface
- `CLK_DIV`, default 27: `clk` cycles per oversample tick, giving bit period = 16*CLK_DIV clocks; legal range 2..65535.
- `clk`  input  1  system clock; all logic is on the rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `rx`  input  1  serial line, asynchronous to `clk`; idle high.
- `rx_byte`  output  8  last good byte, held stable until the next good frame.
- `received`  output  1  one-cycle pulse; `rx_byte` is valid in the same cycle.
- `recv_error`  output  1  one-cycle pulse on a framing error (stop bit sampled 0).
- `break_det`  output  1  one-cycle pulse, coincident with `recv_error`, when the data bits of the failed frame were all 0.
- `is_receiving`  output  1  high in states START, DATA, STOP and WAIT_IDLE.

## Operation
- Input path: a 2-flop synchronizer produces `rx_s`. One further register `rx_d` is used for falling-edge detection (`rx_d`=1, `rx_s`=0).
- Divider: counts 0..CLK_DIV-1 and emits `tick` when it is at CLK_DIV-1. It is cleared on start detection.
- `sample_cnt` (4 bits) increments on each tick and wraps 15->0.
- Majority vote: samples are captured on the ticks where `sample_cnt` is 7, 8 and 9. The bit decision is the majority of the three, taken on tick 9.
- States:
  - IDLE: on a falling edge of `rx_s`, clear the divider and `sample_cnt`, go to START.
  - START: on decision=1 (false start), return to IDLE with no pulse. On decision=0, continue; on the wrap after tick 15, go to DATA with bit index 0.
  - DATA: each decision shifts into the shift register MSB, so the first received bit ends up at `rx_byte[0]` (LSB first). After bit index 7 wraps, go to STOP.
  - STOP, decision=1: assert `received` and load `rx_byte` from the shift register; go to IDLE immediately at mid-stop, so a back-to-back start bit is caught.
  - STOP, decision=0: assert `recv_error`, plus `break_det` if the shift register is 0x00. `rx_byte` is unchanged. Go to WAIT_IDLE.
  - WAIT_IDLE: stay until `rx_s`=1, then go to IDLE. A break is reported only once, however long the line stays low.
- No output holding handshake: a consumer that misses `received` loses the byte. The RX FIFO is always ready.
- Reset values: state IDLE, counters 0, synchronizer and `rx_d` 1, `rx_byte`=0x00, all pulses 0, `is_receiving` 0.
- Reset asserted mid-frame clears everything immediately. No pulse is emitted for the aborted frame. After release, the first frame is recognised only from a fresh falling edge.

## Timing
- All outputs are registered.
- Tick n of a frame (counted from 0 at the start bit) falls d + (n+1)*CLK_DIV clocks after the detection cycle d. Detection d is 3 clocks after the `rx` pin falls (2 synchronizer clocks + 1 edge-register clock).
- `received` / `recv_error` assert 1 clock after the stop-bit decision tick. This is pin falling edge + 154*CLK_DIV + 4 clocks (±1 for the sampling phase of the asynchronous edge).
- `is_receiving`:
  - rises 1 clock after d;
  - falls in the same cycle `received` asserts;
  - after an error, falls 1 clock after `rx_s` returns high.
- A new frame whose falling edge arrives ≥1 clock after return to IDLE is accepted. Minimum inter-frame gap is half a stop bit.
- Tolerance: a sender bit rate within ±3% of nominal must be received error-free.

## Test plan
- Single byte, CLK_DIV=4, send 0xA5 8N1 -> `received` pulses once 620±1 clocks after the start edge with `rx_byte`=0xA5; `recv_error`=0.
- Back-to-back frames: 0x00, 0xFF, 0x55 with no idle gap -> three `received` pulses, bytes in order; `is_receiving` drops only between frames.
- Glitch: `rx` low for 3*CLK_DIV clocks, then high -> no pulse, state back to IDLE, `is_receiving` pulses high then low.
- Framing error: 0x3C sent with stop bit 0, then line high -> `recv_error` 1 clock, `break_det`=0, `rx_byte` keeps its previous value.
- Break: `rx` held low for 20 bit periods -> exactly one `recv_error` + `break_det` pulse; the next valid 0x81 frame is received correctly.
- Reset mid-frame: assert `rst`=0 during DATA bit 4 -> outputs are at reset values within the same cycle, no pulse. After release, a fresh 0x7E frame is received correctly.
- Rate skew: sender at +3% and −3% bit period, 16 random bytes each -> all bytes match, no errors.
